cpu_data_mem_io: RTL and testbench

- Data-side memory stage for the single-cycle CPU. It consumes the CPU's ALU result (address), store data and write enable, and returns load data in the same cycle.
- Contains a word-addressed data RAM plus a small memory-mapped I/O block:
  - LED output register
  - switch input
  - free-running cycle counter
  - down-counting timer with expiry flag and interrupt.

---
 rtl/cpu_data_mem_io.sv | 149 ++++++++++++++
 tb/tb_cpu_data_mem_io.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_mem_io.sv
// Data-side memory stage for the single-cycle CPU: word-addressed RAM plus
// memory-mapped LED, switch, cycle counter and down-counting timer. Loads
// return combinationally; stores and counter updates happen on the rising edge.
`timescale 1ns/1ps
module cpu_data_mem_io #(
  parameter int ADDR_WIDTH = 6,
  parameter int SW_WIDTH   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic                we,
  output logic [31:0]         rdata,
  input  logic [SW_WIDTH-1:0] sw,
  output logic [31:0]         led,
  output logic                irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    SEL_LED    = 3'd0,
    SEL_SW     = 3'd1,
    SEL_CYCLE  = 3'd2,
    SEL_TLOAD  = 3'd3,
    SEL_TCOUNT = 3'd4,
    SEL_TCTRL  = 3'd5,
    SEL_RSV6   = 3'd6,
    SEL_RSV7   = 3'd7
  } io_sel_e;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           led_q, led_d;
  logic [31:0]           cycle_q;
  logic [31:0]           tload_q, tload_d;
  logic [31:0]           tcount_q, tcount_d;
  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic                  exp_q, exp_d;
  logic                  ien_q, ien_d;

  logic                  io_sel;
  io_sel_e               reg_sel;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  ram_we, io_we;
  logic                  wr_led, wr_tload, wr_tctrl;
  logic                  expire;
  logic                  unused_addr;

  // Address decode: bit 31 splits RAM from I/O; byte offset and the bits
  // between the decoded fields are don't-care, so both regions alias.
  assign io_sel      = addr[31];
  assign reg_sel     = io_sel_e'(addr[4:2]);
  assign word_idx    = addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^addr;

  assign ram_we   = we & ~io_sel;
  assign io_we    = we & io_sel;
  assign wr_led   = io_we & (reg_sel == SEL_LED);
  assign wr_tload = io_we & (reg_sel == SEL_TLOAD);
  assign wr_tctrl = io_we & (reg_sel == SEL_TCTRL);

  assign led = led_q;
  assign irq = exp_q & ien_q;

  // Zero-latency load mux from the current address and register state
  always_comb begin
    rdata = 32'd0;
    if (!io_sel) begin
      rdata = mem_q[word_idx];
    end else begin
      case (reg_sel)
        SEL_LED:    rdata = led_q;
        SEL_SW:     rdata = 32'(sw);
        SEL_CYCLE:  rdata = cycle_q;
        SEL_TLOAD:  rdata = tload_q;
        SEL_TCOUNT: rdata = tcount_q;
        SEL_TCTRL:  rdata = {28'd0, ien_q, exp_q, auto_q, en_q};
        default:    rdata = 32'd0;
      endcase
    end
  end

  // Next-state for LED, control bits and timer; a TLOAD write beats the
  // decrement and suppresses expiry, and an expiry beats a W1C clear of EXP
  always_comb begin
    led_d    = led_q;
    tload_d  = tload_q;
    tcount_d = tcount_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ien_d    = ien_q;
    exp_d    = exp_q;
    expire   = 1'b0;

    if (wr_led) led_d = wdata;

    if (wr_tctrl) begin
      en_d   = wdata[0];
      auto_d = wdata[1];
      ien_d  = wdata[3];
      if (wdata[2]) exp_d = 1'b0;
    end

    if (wr_tload) begin
      tload_d  = wdata;
      tcount_d = wdata;
    end else if (en_q) begin
      if (tcount_q > 32'd1) begin
        tcount_d = tcount_q - 32'd1;
      end else if (tcount_q == 32'd1) begin
        expire   = 1'b1;
        tcount_d = auto_q ? tload_q : 32'd0;
      end
    end

    if (expire) exp_d = 1'b1;
  end

  // Register state with asynchronous clear; the cycle counter runs every edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q    <= 32'd0;
      cycle_q  <= 32'd0;
      tload_q  <= 32'd0;
      tcount_q <= 32'd0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      exp_q    <= 1'b0;
      ien_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_q + 32'd1;
      tload_q  <= tload_d;
      tcount_q <= tcount_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      exp_q    <= exp_d;
      ien_q    <= ien_d;
    end
  end

  // Data RAM store; contents survive reset
  always_ff @(posedge clock) begin
    if (ram_we) mem_q[word_idx] <= wdata;
  end

endmodule

// File: tb/tb_cpu_data_mem_io.sv
// Self-checking bench for cpu_data_mem_io: directed scenarios plus a random
// sequence compared against a register-map level reference model.
`timescale 1ns/1ps
module tb_cpu_data_mem_io;

  localparam int          AW  = 6;
  localparam int          SWW = 16;
  localparam logic [31:0] IO  = 32'h8000_0000;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [31:0]     addr, wdata;
  logic            we;
  logic [SWW-1:0]  sw;
  logic [31:0]     rdata, led;
  logic            irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_ram [64];
  bit          m_valid [64];
  logic [31:0] m_led, m_cycle, m_tload, m_tcount;
  bit          m_en, m_auto, m_exp, m_ien;

  cpu_data_mem_io #(.ADDR_WIDTH(AW), .SW_WIDTH(SWW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .sw      (sw),
    .led     (led),
    .irq     (irq)
  );

  always #10 clock = ~clock;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!a[31]) return m_ram[a[7:2]];
    case (a[4:2])
      3'd0:    return m_led;
      3'd1:    return {16'd0, sw};
      3'd2:    return m_cycle;
      3'd3:    return m_tload;
      3'd4:    return m_tcount;
      3'd5:    return {28'd0, m_ien, m_exp, m_auto, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_led = 0; m_cycle = 0; m_tload = 0; m_tcount = 0;
    m_en = 0; m_auto = 0; m_exp = 0; m_ien = 0;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr = a; wdata = d; we = w;
  endtask

  // One clock edge: advance the model from the inputs present at the edge
  task automatic tick();
    logic [31:0] tl, tc;
    bit en, au, loaded, expire, clr;
    @(posedge clock);
    tl = m_tload; tc = m_tcount; en = m_en; au = m_auto;
    loaded = 0; expire = 0; clr = 0;
    m_cycle = m_cycle + 32'd1;
    if (we && !addr[31]) begin
      m_ram[addr[7:2]]   = wdata;
      m_valid[addr[7:2]] = 1'b1;
    end
    if (we && addr[31]) begin
      case (addr[4:2])
        3'd0: m_led = wdata;
        3'd3: begin m_tload = wdata; m_tcount = wdata; loaded = 1; end
        3'd5: begin
          m_en = wdata[0]; m_auto = wdata[1]; m_ien = wdata[3]; clr = wdata[2];
        end
        default: ;
      endcase
    end
    if (!loaded && en) begin
      if (tc > 32'd1) m_tcount = tc - 32'd1;
      else if (tc == 32'd1) begin
        expire   = 1;
        m_tcount = au ? tl : 32'd0;
      end
    end
    if (expire) m_exp = 1;
    else if (clr) m_exp = 0;
    @(negedge clock);
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    apply(a, d, w);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    logic [31:0] regs [5];
    regs = '{IO, IO | 32'h8, IO | 32'hC, IO | 32'h10, IO | 32'h14};
    #5;
    n_cmp++;
    if (led !== 32'd0) begin n_bad++; $display("FAIL reset_led got=%h want=0", led); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    foreach (regs[i]) begin
      apply(regs[i], 32'd0, 1'b0);
      #0.5;
      n_cmp++;
      if (rdata !== 32'd0) begin
        n_bad++; $display("FAIL reset_reg addr=%h got=%h want=0", regs[i], rdata);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_ram();
    logic [31:0] rd_addrs [3];
    rd_addrs = '{32'h0000_0010, 32'h0000_0013, 32'h0000_0110};
    cyc(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    foreach (rd_addrs[i]) begin
      apply(rd_addrs[i], 32'd0, 1'b0);
      #1;
      n_cmp++;
      if (rdata !== 32'hDEAD_BEEF) begin
        n_bad++; $display("FAIL ram_load addr=%h got=%h want=deadbeef", rd_addrs[i], rdata);
      end
    end
    tick();
  endtask

  task automatic test_io();
    cyc(IO, 32'h0000_00A5, 1'b1);
    #1;
    n_cmp++;
    if (led !== 32'hA5) begin n_bad++; $display("FAIL io_led got=%h want=000000a5", led); end
    sw = 16'h1234;
    apply(IO | 32'h4, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL io_sw got=%h want=00001234", rdata); end
    cyc(IO | 32'h4, 32'hFFFF_FFFF, 1'b1);
    apply(IO | 32'h4, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL io_sw_ro got=%h want=00001234", rdata); end
    n_cmp++;
    if (led !== 32'hA5) begin n_bad++; $display("FAIL io_led_hold got=%h want=000000a5", led); end
    cyc(IO | 32'h18, 32'hFFFF_FFFF, 1'b1);
    apply(IO | 32'h18, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_bad++; $display("FAIL io_rsv18 got=%h want=0", rdata); end
    apply(IO | 32'h1C, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_bad++; $display("FAIL io_rsv1c got=%h want=0", rdata); end
    tick();
  endtask

  task automatic test_cycle();
    do_reset();
    apply(IO | 32'h8, 32'd0, 1'b0);
    repeat (10) tick();
    #1;
    n_cmp++;
    if (rdata !== 32'd10) begin n_bad++; $display("FAIL cycle_10 got=%0d want=10", rdata); end
    dut.cycle_q = 32'hFFFF_FFFF;
    m_cycle     = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL cycle_preload got=%h want=ffffffff", rdata); end
    tick();
    #1;
    n_cmp++;
    if (rdata !== 32'd0) begin n_bad++; $display("FAIL cycle_wrap got=%h want=0", rdata); end
  endtask

  task automatic test_oneshot();
    int seq [4];
    seq = '{3, 2, 1, 0};
    do_reset();
    cyc(IO | 32'hC, 32'd3, 1'b1);
    cyc(IO | 32'h14, 32'h9, 1'b1);
    apply(IO | 32'h10, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (rdata !== 32'(seq[k])) begin
        n_bad++; $display("FAIL oneshot_count step=%0d got=%0d want=%0d", k, rdata, seq[k]);
      end
      n_cmp++;
      if (irq !== (k == 3)) begin
        n_bad++; $display("FAIL oneshot_irq step=%0d got=%b want=%b", k, irq, (k == 3));
      end
      if (k < 3) tick();
    end
    repeat (3) tick();
    #1;
    n_cmp++;
    if (rdata !== 32'd0 || irq !== 1'b1) begin
      n_bad++; $display("FAIL oneshot_hold count=%0d irq=%b want count=0 irq=1", rdata, irq);
    end
    cyc(IO | 32'h14, 32'hD, 1'b1);
    apply(IO | 32'h14, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'h9 || irq !== 1'b0) begin
      n_bad++; $display("FAIL oneshot_w1c tctrl=%h irq=%b want tctrl=9 irq=0", rdata, irq);
    end
    tick();
  endtask

  task automatic test_auto();
    do_reset();
    cyc(IO | 32'hC, 32'd2, 1'b1);
    cyc(IO | 32'h14, 32'hB, 1'b1);
    apply(IO | 32'h10, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'd2) begin n_bad++; $display("FAIL auto_c0 got=%0d want=2", rdata); end
    tick();
    #1;
    n_cmp++;
    if (rdata !== 32'd1) begin n_bad++; $display("FAIL auto_c1 got=%0d want=1", rdata); end
    tick();
    #1;
    n_cmp++;
    if (rdata !== 32'd2 || irq !== 1'b1) begin
      n_bad++; $display("FAIL auto_reload count=%0d irq=%b want count=2 irq=1", rdata, irq);
    end
    // clear EXP while count steps 2->1
    cyc(IO | 32'h14, 32'hF, 1'b1);
    apply(IO | 32'h14, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'hB) begin n_bad++; $display("FAIL auto_clear tctrl=%h want=b", rdata); end
    // W1C on the expiry edge: set wins
    cyc(IO | 32'h14, 32'hF, 1'b1);
    apply(IO | 32'h14, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'hF || irq !== 1'b1) begin
      n_bad++; $display("FAIL auto_setwins tctrl=%h irq=%b want tctrl=f irq=1", rdata, irq);
    end
    cyc(IO | 32'h14, 32'hF, 1'b1);
    // TLOAD write while count is 1: reload, no expiry
    cyc(IO | 32'hC, 32'd5, 1'b1);
    apply(IO | 32'h10, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'd5) begin n_bad++; $display("FAIL auto_tload_count got=%0d want=5", rdata); end
    apply(IO | 32'h14, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'hB || irq !== 1'b0) begin
      n_bad++; $display("FAIL auto_tload_noexp tctrl=%h irq=%b want tctrl=b irq=0", rdata, irq);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] chk_a [4];
    logic [31:0] chk_v [4];
    chk_a = '{IO | 32'h10, IO | 32'h14, IO | 32'h8, 32'h0000_0010};
    chk_v = '{32'd0, 32'd0, 32'd0, 32'h55};
    do_reset();
    cyc(32'h0000_0010, 32'h55, 1'b1);
    cyc(IO, 32'hFF, 1'b1);
    cyc(IO | 32'hC, 32'd1, 1'b1);
    cyc(IO | 32'h14, 32'h9, 1'b1);
    apply(IO | 32'h10, 32'd0, 1'b0);
    tick();
    cyc(IO | 32'hC, 32'd7, 1'b1);
    apply(IO | 32'h10, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (rdata !== 32'd7 || irq !== 1'b1 || led !== 32'hFF) begin
      n_bad++; $display("FAIL areset_pre count=%0d irq=%b led=%h want 7/1/ff", rdata, irq, led);
    end
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (led !== 32'd0 || irq !== 1'b0) begin
      n_bad++; $display("FAIL areset_out led=%h irq=%b want 0/0", led, irq);
    end
    foreach (chk_a[i]) begin
      apply(chk_a[i], 32'd0, 1'b0);
      #1;
      n_cmp++;
      if (rdata !== chk_v[i]) begin
        n_bad++; $display("FAIL areset_read addr=%h got=%h want=%h", chk_a[i], rdata, chk_v[i]);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, d, r, expv;
    logic w;
    int kind, sel;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r    = $urandom();
      kind = $urandom_range(0, 9);
      sel  = $urandom_range(0, 7);
      if (kind < 3) a = r & 32'h7FFF_FFFF;
      else          a = IO | (r & 32'h7FFF_FFE3) | (32'(sel) << 2);
      d = $urandom();
      if (a[31] && sel == 3) d = $urandom_range(0, 6);
      if (a[31] && sel == 5 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      w  = 1'($urandom_range(0, 1));
      sw = 16'($urandom());
      apply(a, d, w);
      #1;
      if (a[31] || m_valid[a[7:2]]) begin
        expv = m_read(a);
        n_cmp++;
        if (rdata !== expv) begin
          n_bad++; $display("FAIL rand_rdata i=%0d addr=%h got=%h want=%h", i, a, rdata, expv);
        end
      end
      n_cmp++;
      if (led !== m_led || irq !== (m_exp & m_ien)) begin
        n_bad++; $display("FAIL rand_out i=%0d led=%h irq=%b want led=%h irq=%b",
                          i, led, irq, m_led, m_exp & m_ien);
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    addr = 32'd0; wdata = 32'd0; we = 1'b0; sw = '0;
    m_reset();
    test_reset();
    test_ram();
    test_io();
    test_cycle();
    test_oneshot();
    test_auto();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
